// File: rtl/dense_seq_ctrl.sv
// -----------------------------------------------------------------------------
// dense_seq_ctrl
//   Sequencer for a time-multiplexed fp32 dense layer. A single MAC computes
//   all BIAS neurons one after another. For each neuron the block walks NUMS
//   inputs, issues input/weight/bias read addresses and MAC strobes, waits for
//   the accumulated (+bias) result and issues one result write.
//
// Optional feature macro: DENSE_CTRL_PERF_EN
//   When defined, adds perf_cycles_o / perf_stalls_o performance counters.
//
// Ports
//   clk          in   rising-edge clock
//   reset_n      in   asynchronous active-low reset
//   start_i      in   start request, sampled only in IDLE
//   stall_i      in   memory/MAC not ready, freezes issue (ISSUE only)
//   acc_valid_i  in   MAC final sum valid (one cycle), honoured only in DRAIN
//   busy_o       out  run in progress (ISSUE..DONE)
//   done_o       out  one-cycle pulse after the last result write
//   rd_en_o      out  read strobe to input buffer, weight ROM, bias ROM
//   in_addr_o    out  input index i
//   w_addr_o     out  weight index n*NUMS + i
//   b_addr_o     out  neuron / bias index n
//   mac_valid_o  out  operands valid at MAC (rd_en_o delayed one cycle)
//   mac_first_o  out  with mac_valid_o: first term of a neuron
//   mac_last_o   out  with mac_valid_o: last term of a neuron
//   perf_cycles_o out busy cycles of the last/current run (macro only)
//   perf_stalls_o out stalled ISSUE cycles of the last/current run (macro only)
//   wr_en_o      out  result RAM write strobe
//   wr_addr_o    out  result index n
// -----------------------------------------------------------------------------
// state   | meaning
// IDLE    | waiting for start_i
// ISSUE   | issuing reads for inputs 0..NUMS-1 of neuron n
// DRAIN   | waiting for the MAC result of neuron n
// WRITE   | one-cycle result write for neuron n
// DONE    | one-cycle done pulse, then back to IDLE
// -----------------------------------------------------------------------------
module dense_seq_ctrl #(
    parameter int NUMS       = 1600,
    parameter int BIAS       = 128,
    parameter int DATA_WIDTH = 32,
    localparam int IA_W = (NUMS > 1) ? $clog2(NUMS) : 1,
    localparam int WA_W = ((NUMS * BIAS) > 1) ? $clog2(NUMS * BIAS) : 1,
    localparam int BA_W = (BIAS > 1) ? $clog2(BIAS) : 1
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic            start_i,
    input  logic            stall_i,
    input  logic            acc_valid_i,
    output logic            busy_o,
    output logic            done_o,
    output logic            rd_en_o,
    output logic [IA_W-1:0] in_addr_o,
    output logic [WA_W-1:0] w_addr_o,
    output logic [BA_W-1:0] b_addr_o,
    output logic            mac_valid_o,
    output logic            mac_first_o,
    output logic            mac_last_o,
    output logic            wr_en_o,
`ifdef DENSE_CTRL_PERF_EN
    output logic [31:0]     perf_cycles_o,
    output logic [31:0]     perf_stalls_o,
`endif
    output logic [BA_W-1:0] wr_addr_o
);

    // DATA_WIDTH only documents the word size the addresses index.
    if (!(NUMS >= 2 && BIAS >= 1 && DATA_WIDTH > 0)) begin : g_bad_params
        $error("dense_seq_ctrl: NUMS must be >= 2, BIAS >= 1, DATA_WIDTH > 0");
    end

    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE,
        S_DRAIN,
        S_WRITE,
        S_DONE
    } state_t;

    state_t          r_state;
    state_t          w_state_nxt;
    logic [IA_W-1:0] r_i;
    logic [WA_W-1:0] r_w;
    logic [BA_W-1:0] r_n;
    logic            r_mac_valid;
    logic            r_mac_first;
    logic            r_mac_last;

    logic w_start;
    logic w_issue;
    logic w_i_last;
    logic w_n_last;
    logic w_acc;

    assign w_start  = (r_state == S_IDLE) && start_i;
    assign w_issue  = (r_state == S_ISSUE) && !stall_i;
    assign w_i_last = (r_i == IA_W'(NUMS - 1));
    assign w_n_last = (r_n == BA_W'(BIAS - 1));
    // A result pulse coinciding with the last-term strobe cannot belong to
    // this neuron's sum yet, so it is discarded.
    assign w_acc    = (r_state == S_DRAIN) && acc_valid_i && !r_mac_last;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (start_i) w_state_nxt = S_ISSUE;
            S_ISSUE: if (w_issue && w_i_last) w_state_nxt = S_DRAIN;
            S_DRAIN: if (w_acc) w_state_nxt = S_WRITE;
            S_WRITE: w_state_nxt = w_n_last ? S_DONE : S_ISSUE;
            S_DONE:  w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // The input counter is rewound when the next neuron starts rather than
    // when the last read issues, so the address outputs keep showing the last
    // issued location through DRAIN, WRITE and IDLE. r_w tracks n*NUMS+i
    // incrementally, avoiding a multiplier.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_i <= '0;
            r_w <= '0;
            r_n <= '0;
        end else if (w_start) begin
            r_i <= '0;
            r_w <= '0;
            r_n <= '0;
        end else if (w_issue && !w_i_last) begin
            r_i <= r_i + 1'b1;
            r_w <= r_w + 1'b1;
        end else if ((r_state == S_WRITE) && !w_n_last) begin
            r_i <= '0;
            r_w <= r_w + 1'b1;
            r_n <= r_n + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_mac_valid <= 1'b0;
            r_mac_first <= 1'b0;
            r_mac_last  <= 1'b0;
        end else begin
            r_mac_valid <= w_issue;
            r_mac_first <= w_issue && (r_i == '0);
            r_mac_last  <= w_issue && w_i_last;
        end
    end

`ifdef DENSE_CTRL_PERF_EN
    logic [31:0] r_perf_cycles;
    logic [31:0] r_perf_stalls;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_perf_cycles <= '0;
            r_perf_stalls <= '0;
        end else if (w_start) begin
            r_perf_cycles <= '0;
            r_perf_stalls <= '0;
        end else begin
            if (r_state != S_IDLE) r_perf_cycles <= r_perf_cycles + 32'd1;
            if ((r_state == S_ISSUE) && stall_i) r_perf_stalls <= r_perf_stalls + 32'd1;
        end
    end

    assign perf_cycles_o = r_perf_cycles;
    assign perf_stalls_o = r_perf_stalls;
`endif

    assign busy_o      = (r_state != S_IDLE);
    assign done_o      = (r_state == S_DONE);
    assign rd_en_o     = w_issue;
    assign in_addr_o   = r_i;
    assign w_addr_o    = r_w;
    assign b_addr_o    = r_n;
    assign mac_valid_o = r_mac_valid;
    assign mac_first_o = r_mac_first;
    assign mac_last_o  = r_mac_last;
    assign wr_en_o     = (r_state == S_WRITE);
    assign wr_addr_o   = r_n;

endmodule

// File: tb/tb_dense_seq_ctrl.sv
// -----------------------------------------------------------------------------
// tb_dense_seq_ctrl
//   Bench for dense_seq_ctrl with NUMS=4, BIAS=2. A MAC model answers each
//   last-term strobe with acc_valid_i a configurable number of cycles later.
//   Expected event timelines are built from the stall pattern and MAC latency.
// -----------------------------------------------------------------------------
module tb_dense_seq_ctrl;

    localparam int NUMS = 4;
    localparam int BIAS = 2;

    logic       clk = 1'b0;
    logic       reset_n;
    logic       start_i;
    logic       stall_i;
    logic       acc_valid_i;
    logic       busy_o;
    logic       done_o;
    logic       rd_en_o;
    logic [1:0] in_addr_o;
    logic [2:0] w_addr_o;
    logic [0:0] b_addr_o;
    logic       mac_valid_o;
    logic       mac_first_o;
    logic       mac_last_o;
    logic       wr_en_o;
    logic [0:0] wr_addr_o;
`ifdef DENSE_CTRL_PERF_EN
    logic [31:0] perf_cycles_o;
    logic [31:0] perf_stalls_o;
`endif

    dense_seq_ctrl #(.NUMS(NUMS), .BIAS(BIAS), .DATA_WIDTH(32)) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .start_i     (start_i),
        .stall_i     (stall_i),
        .acc_valid_i (acc_valid_i),
        .busy_o      (busy_o),
        .done_o      (done_o),
        .rd_en_o     (rd_en_o),
        .in_addr_o   (in_addr_o),
        .w_addr_o    (w_addr_o),
        .b_addr_o    (b_addr_o),
        .mac_valid_o (mac_valid_o),
        .mac_first_o (mac_first_o),
        .mac_last_o  (mac_last_o),
        .wr_en_o     (wr_en_o),
`ifdef DENSE_CTRL_PERF_EN
        .perf_cycles_o (perf_cycles_o),
        .perf_stalls_o (perf_stalls_o),
`endif
        .wr_addr_o   (wr_addr_o)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc;

    int rd_c[$], rd_i[$], rd_w[$], rd_b[$];
    int mac_c[$], mac_f[$], mac_l[$];
    int wr_c[$], wr_a[$], done_c[$], busy_c[$];
    int acc_due[$];

    typedef struct {
        logic [31:0] mask;
        int          lat;
        int          spur;
        bit          hold;
        int          exp_done;
        int          exp_busy;
    } vec_t;

    vec_t tbl[6];

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic clear_logs();
        rd_c.delete(); rd_i.delete(); rd_w.delete(); rd_b.delete();
        mac_c.delete(); mac_f.delete(); mac_l.delete();
        wr_c.delete(); wr_a.delete(); done_c.delete(); busy_c.delete();
        acc_due.delete();
        cyc = 0;
    endtask

    // One clock cycle: drive inputs after the falling edge, sample 1 ns later.
    task automatic step(input bit st, input bit stl, input bit extra_acc, input int lat);
        bit acc;
        @(negedge clk);
        acc = extra_acc;
        foreach (acc_due[k]) if (acc_due[k] == cyc) acc = 1'b1;
        start_i     = st;
        stall_i     = stl;
        acc_valid_i = acc;
        #1;
        if (busy_o) busy_c.push_back(cyc);
        if (rd_en_o) begin
            rd_c.push_back(cyc);
            rd_i.push_back(int'(in_addr_o));
            rd_w.push_back(int'(w_addr_o));
            rd_b.push_back(int'(b_addr_o));
        end
        if (mac_valid_o) begin
            mac_c.push_back(cyc);
            mac_f.push_back(int'(mac_first_o));
            mac_l.push_back(int'(mac_last_o));
            if (mac_last_o) acc_due.push_back(cyc + lat);
        end
        if (wr_en_o) begin
            wr_c.push_back(cyc);
            wr_a.push_back(int'(wr_addr_o));
        end
        if (done_o) done_c.push_back(cyc);
        cyc++;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_busy"},  int'(busy_o), 0);
        check({tag, "_done"},  int'(done_o), 0);
        check({tag, "_rd_en"}, int'(rd_en_o), 0);
        check({tag, "_in"},    int'(in_addr_o), 0);
        check({tag, "_w"},     int'(w_addr_o), 0);
        check({tag, "_b"},     int'(b_addr_o), 0);
        check({tag, "_mv"},    int'(mac_valid_o), 0);
        check({tag, "_mf"},    int'(mac_first_o), 0);
        check({tag, "_ml"},    int'(mac_last_o), 0);
        check({tag, "_wr_en"}, int'(wr_en_o), 0);
        check({tag, "_wr_a"},  int'(wr_addr_o), 0);
    endtask

    function automatic bit stalled(input logic [31:0] mask, input int t);
        return (t >= 0 && t < 32) ? mask[t] : 1'b0;
    endfunction

    // spur: -1 none, -2 random cycle inside neuron 0's issue window.
    task automatic run_case(input string tag, input logic [31:0] mask, input int lat,
                            input int spur_in, input bit hold,
                            input int exp_done, input int exp_busy);
        int e_rc[$], e_ri[$], e_rw[$], e_rb[$], e_wc[$], e_wa[$], e_dc[$], e_st[$];
        int s, t, wr, stl, e_busy, runs, last_cyc, spur, b1;
        clear_logs();
        runs   = hold ? 2 : 1;
        s      = 0;
        e_busy = 0;
        for (int r = 0; r < runs; r++) begin
            e_st.push_back(s);
            t   = s + 1;
            stl = 0;
            for (int n = 0; n < BIAS; n++) begin
                for (int i = 0; i < NUMS; i++) begin
                    while (stalled(mask, t)) begin t++; stl++; end
                    e_rc.push_back(t); e_ri.push_back(i);
                    e_rw.push_back(n * NUMS + i); e_rb.push_back(n);
                    t++;
                end
                wr = t + lat + 1;
                e_wc.push_back(wr); e_wa.push_back(n);
                t = wr + 1;
            end
            e_dc.push_back(t);
            e_busy += t - s;
            s = t + 1;
        end
        spur = (spur_in == -2) ? int'($urandom_range(1, e_rc[NUMS-1] + 1)) : spur_in;
        last_cyc = e_dc[e_dc.size()-1] + 4;

        while (cyc <= last_cyc) begin
            step(hold ? (cyc <= e_dc[0] + 1) : (cyc == 0), stalled(mask, cyc), cyc == spur, lat);
`ifdef DENSE_CTRL_PERF_EN
            foreach (e_st[k]) if (cyc - 1 == e_st[k] + 1) begin
                check({tag, "_perf_cyc_clear"}, int'(perf_cycles_o), 0);
                check({tag, "_perf_stl_clear"}, int'(perf_stalls_o), 0);
            end
`endif
        end

        check({tag, "_rd_count"}, rd_c.size(), e_rc.size());
        for (int k = 0; k < rd_c.size() && k < e_rc.size(); k++) begin
            check($sformatf("%s_rd%0d_cyc", tag, k), rd_c[k], e_rc[k]);
            check($sformatf("%s_rd%0d_in", tag, k), rd_i[k], e_ri[k]);
            check($sformatf("%s_rd%0d_w", tag, k), rd_w[k], e_rw[k]);
            check($sformatf("%s_rd%0d_b", tag, k), rd_b[k], e_rb[k]);
        end
        check({tag, "_mac_count"}, mac_c.size(), e_rc.size());
        for (int k = 0; k < mac_c.size() && k < e_rc.size(); k++) begin
            check($sformatf("%s_mac%0d_cyc", tag, k), mac_c[k], e_rc[k] + 1);
            check($sformatf("%s_mac%0d_first", tag, k), mac_f[k], int'(k % NUMS == 0));
            check($sformatf("%s_mac%0d_last", tag, k), mac_l[k], int'(k % NUMS == NUMS - 1));
        end
        check({tag, "_wr_count"}, wr_c.size(), e_wc.size());
        for (int k = 0; k < wr_c.size() && k < e_wc.size(); k++) begin
            check($sformatf("%s_wr%0d_cyc", tag, k), wr_c[k], e_wc[k]);
            check($sformatf("%s_wr%0d_addr", tag, k), wr_a[k], e_wa[k]);
        end
        check({tag, "_done_count"}, done_c.size(), e_dc.size());
        for (int k = 0; k < done_c.size() && k < e_dc.size(); k++)
            check($sformatf("%s_done%0d_cyc", tag, k), done_c[k], e_dc[k]);
        check({tag, "_busy_total"}, busy_c.size(), e_busy);

        if (exp_done >= 0 && done_c.size() > 0) begin
            check({tag, "_tbl_done"}, done_c[0], exp_done);
            b1 = 0;
            foreach (busy_c[k]) if (busy_c[k] <= done_c[0]) b1++;
            check({tag, "_tbl_busy"}, b1, exp_busy);
        end

        check({tag, "_idle_in"},   int'(in_addr_o), NUMS - 1);
        check({tag, "_idle_w"},    int'(w_addr_o), NUMS * BIAS - 1);
        check({tag, "_idle_b"},    int'(b_addr_o), BIAS - 1);
        check({tag, "_idle_wr_a"}, int'(wr_addr_o), BIAS - 1);
`ifdef DENSE_CTRL_PERF_EN
        check({tag, "_perf_cycles"}, int'(perf_cycles_o), e_dc[runs-1] - e_st[runs-1]);
        check({tag, "_perf_stalls"}, int'(perf_stalls_o), stl);
`endif
    endtask

    initial begin
        //          mask          lat spur hold done busy
        tbl[0] = '{32'h0000_0000,  3, -1, 1'b0, 19, 19};
        tbl[1] = '{32'h0000_0018,  3, -1, 1'b0, 21, 21};
        tbl[2] = '{32'h0000_01E0,  3, -1, 1'b0, 19, 19};
        tbl[3] = '{32'h0000_0000, 10,  2, 1'b0, 33, 33};
        tbl[4] = '{32'h0000_0000,  3,  5, 1'b0, 19, 19};
        tbl[5] = '{32'h0000_0000,  3, -1, 1'b1, 19, 19};

        reset_n     = 1'b0;
        start_i     = 1'b0;
        stall_i     = 1'b0;
        acc_valid_i = 1'b0;
        #1;
        check_all_zero("reset");
`ifdef DENSE_CTRL_PERF_EN
        check("reset_perf_cycles", int'(perf_cycles_o), 0);
        check("reset_perf_stalls", int'(perf_stalls_o), 0);
`endif
        repeat (2) @(negedge clk);
        reset_n = 1'b1;

        for (int v = 0; v < 6; v++)
            run_case($sformatf("vec%0d", v), tbl[v].mask, tbl[v].lat, tbl[v].spur,
                     tbl[v].hold, tbl[v].exp_done, tbl[v].exp_busy);

        // Reset while neuron 0 drains (mac_last_o is high in that cycle).
        clear_logs();
        step(1'b1, 1'b0, 1'b0, 3);
        for (int k = 1; k < 5; k++) step(1'b0, 1'b0, 1'b0, 3);
        @(negedge clk);
        check("abort_pre_ml", int'(mac_last_o), 1);
        reset_n = 1'b0;
        #1;
        check_all_zero("abort");
        cyc++;
        for (int k = 0; k < 6; k++) step(1'b0, 1'b0, 1'b0, 3);
        check("abort_wr_count", wr_c.size(), 0);
        check("abort_done_count", done_c.size(), 0);
        @(negedge clk);
        reset_n = 1'b1;
        run_case("after_abort", 32'h0, 3, -1, 1'b0, 19, 19);

        for (int r = 0; r < 8; r++)
            run_case($sformatf("rnd%0d", r), $urandom & $urandom,
                     int'($urandom_range(1, 8)), -2, 1'b0, -1, -1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
